channel_select: RTL and testbench

Runtime-programmable channel selector placed directly after the channelizer's DIT stage. It tracks channel position within each N-channel frame and checks alignment against the upstream frame marker. Only channels enabled in a mask are forwarded, and each output sample is tagged with its channel index. The mask is reloaded through the message bus and applied only on a frame boundary, so a frame is never split between two masks.

---
 rtl/channel_select.sv | 143 ++++++++++++++
 tb/tb_channel_select.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_select.sv
// Channel selector behind the channelizer DIT stage. It tracks the position inside each
// N-channel frame, checks it against in_first, and forwards masked channels tagged with their index.
module channel_select #(
  parameter int           N            = 8,
  parameter int           LOGN         = 3,
  parameter int           WDTH         = 32,
  parameter int           MWDTH        = 1,
  parameter int           MSG_WIDTH    = 32,
  parameter logic [N-1:0] DEFAULT_MASK = {N{1'b1}},
  parameter bit           RESYNC       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WDTH-1:0]      in_data,
  input  logic                 in_nd,
  input  logic [MWDTH-1:0]     in_m,
  input  logic                 in_first,
  input  logic [MSG_WIDTH-1:0] in_msg,
  input  logic                 in_msg_nd,
  output logic [WDTH-1:0]      out_data,
  output logic                 out_nd,
  output logic [MWDTH-1:0]     out_m,
  output logic [LOGN-1:0]      out_chan,
  output logic                 out_first_channel,
  output logic                 locked,
  output logic                 error
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [LOGN-1:0] LAST_CHAN = LOGN'(N - 1);
  localparam logic [1:0]      OP_WRITE  = 2'b10;
  localparam logic [1:0]      OP_COMMIT = 2'b11;

  state_t          state;
  logic [LOGN-1:0] cnt;
  logic [N-1:0]    active_mask;
  logic [N-1:0]    pending_mask;
  logic            commit_pending;
  logic            seen_fwd;

  logic            proc;
  logic            misalign;
  logic            is_ch0;
  logic            apply;
  logic            fwd;
  logic            first_fwd;
  logic [LOGN-1:0] chan;
  logic [LOGN-1:0] next_cnt;
  logic [N-1:0]    mask_eff;
  logic [1:0]      opcode;
  logic [13:0]     chunk;

  assign opcode = in_msg[MSG_WIDTH-1 -: 2];
  assign chunk  = in_msg[29:16];

  generate
    if (MSG_WIDTH > 32) begin : g_wide_msg
      logic unused_msg;
      assign unused_msg = ^in_msg[MSG_WIDTH-3:30];
    end
  endgenerate

  // Decide which channel (if any) the incoming sample occupies and whether it is forwarded.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block infers a latch.
    proc     = 1'b0;
    misalign = 1'b0;
    chan     = cnt;
    if (in_nd) begin
      if (state == SEARCH) begin
        proc = in_first;
        chan = '0;
      end else begin
        proc     = 1'b1;
        misalign = in_first ? (cnt != '0) : (cnt == '0);
        if (RESYNC && in_first) chan = '0;
      end
    end
    next_cnt  = (chan == LAST_CHAN) ? '0 : chan + LOGN'(1);
    is_ch0    = proc && (chan == '0);
    // A pending commit takes effect on the channel-0 sample itself.
    apply     = is_ch0 && commit_pending;
    mask_eff  = apply ? pending_mask : active_mask;
    fwd       = proc && mask_eff[chan];
    first_fwd = fwd && (is_ch0 || !seen_fwd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= SEARCH;
      cnt               <= '0;
      active_mask       <= DEFAULT_MASK;
      pending_mask      <= DEFAULT_MASK;
      commit_pending    <= 1'b0;
      seen_fwd          <= 1'b0;
      out_data          <= '0;
      out_nd            <= 1'b0;
      out_m             <= '0;
      out_chan          <= '0;
      out_first_channel <= 1'b0;
      locked            <= 1'b0;
      error             <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read above sees pre-edge values.
      out_nd            <= fwd;
      out_first_channel <= first_fwd;
      if (fwd) begin
        out_data <= in_data;
        out_m    <= in_m;
        out_chan <= chan;
      end

      if (proc) begin
        cnt      <= next_cnt;
        seen_fwd <= is_ch0 ? fwd : (seen_fwd | fwd);
      end

      if (in_nd && (state == SEARCH) && in_first) begin
        state  <= LOCKED;
        locked <= 1'b1;
      end

      if (misalign) error <= 1'b1;

      if (apply) begin
        active_mask    <= pending_mask;
        commit_pending <= 1'b0;
      end

      // A commit seen here is registered after the apply check, so it waits for the next channel 0.
      if (in_msg_nd) begin
        if (opcode == OP_COMMIT) commit_pending <= 1'b1;
        if (opcode == OP_WRITE) begin
          for (int j = 0; j < N; j++) begin
            if (int'(chunk) == j / 16) pending_mask[j] <= in_msg[j % 16];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_select.sv
// Directed bench for channel_select (N=8): two instances share stimulus, one with RESYNC=1
// and one with RESYNC=0. Inputs change on the falling edge; outputs are sampled there too.
module tb_channel_select;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_nd;
  logic [0:0]  in_m;
  logic        in_first;
  logic [31:0] in_msg;
  logic        in_msg_nd;

  logic [31:0] out_data_a, out_data_b;
  logic        out_nd_a, out_nd_b;
  logic [0:0]  out_m_a, out_m_b;
  logic [2:0]  out_chan_a, out_chan_b;
  logic        out_first_a, out_first_b;
  logic        locked_a, locked_b;
  logic        error_a, error_b;

  int n_vec = 0;
  int n_bad = 0;
  int seq   = 0;

  localparam logic [31:0] MSG_NONE   = 32'h0;
  localparam logic [31:0] MSG_COMMIT = {2'b11, 30'd0};

  always #5 clk = ~clk;

  channel_select #(.N(N), .LOGN(3), .WDTH(32), .MWDTH(1), .MSG_WIDTH(32), .RESYNC(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m), .in_first(in_first),
    .in_msg(in_msg), .in_msg_nd(in_msg_nd), .out_data(out_data_a), .out_nd(out_nd_a), .out_m(out_m_a),
    .out_chan(out_chan_a), .out_first_channel(out_first_a), .locked(locked_a), .error(error_a)
  );

  channel_select #(.N(N), .LOGN(3), .WDTH(32), .MWDTH(1), .MSG_WIDTH(32), .RESYNC(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_nd(in_nd), .in_m(in_m), .in_first(in_first),
    .in_msg(in_msg), .in_msg_nd(in_msg_nd), .out_data(out_data_b), .out_nd(out_nd_b), .out_m(out_m_b),
    .out_chan(out_chan_b), .out_first_channel(out_first_b), .locked(locked_b), .error(error_b)
  );

  function automatic logic [31:0] wr_msg(input int chunk, input logic [15:0] bits);
    return {2'b10, 14'(chunk), bits};
  endfunction

  // Present one input cycle and advance to the falling edge where its result is visible.
  task automatic drive(input logic nd, input logic first, input logic [31:0] msg, input logic msg_nd);
    seq++;
    in_nd     = nd;
    in_first  = first;
    in_data   = 32'hC0DE_0000 | 32'(seq);
    in_m      = 1'(seq);
    in_msg    = msg;
    in_msg_nd = msg_nd;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, MSG_NONE, 1'b0);
    drive(1'b0, 1'b0, MSG_NONE, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({out_nd_a, out_data_a, out_m_a, out_chan_a, out_first_a, locked_a, error_a} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_a: got nd=%b data=%h m=%b chan=%0d first=%b locked=%b error=%b, want all 0",
               out_nd_a, out_data_a, out_m_a, out_chan_a, out_first_a, locked_a, error_a);
    end
    n_vec++;
    if ({out_nd_b, out_data_b, out_m_b, out_chan_b, out_first_b, locked_b, error_b} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_b: got nd=%b data=%h m=%b chan=%0d first=%b locked=%b error=%b, want all 0",
               out_nd_b, out_data_b, out_m_b, out_chan_b, out_first_b, locked_b, error_b);
    end
  endtask

  task automatic test_search_drop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, MSG_NONE, 1'b0);
      n_vec++;
      if ({out_nd_a, locked_a} !== 2'b00) begin
        n_bad++;
        $display("FAIL search_drop[%0d]: got nd=%b locked=%b, want nd=0 locked=0", i, out_nd_a, locked_a);
      end
    end
    drive(1'b1, 1'b1, MSG_NONE, 1'b0);
    n_vec++;
    if ({out_nd_a, out_chan_a, out_first_a, locked_a, out_data_a} !== {1'b1, 3'd0, 1'b1, 1'b1, in_data}) begin
      n_bad++;
      $display("FAIL search_lock: got nd=%b chan=%0d first=%b locked=%b data=%h, want 1 0 1 1 %h",
               out_nd_a, out_chan_a, out_first_a, locked_a, out_data_a, in_data);
    end
  endtask

  task automatic test_default_frames();
    do_reset();
    for (int i = 0; i < 3 * N; i++) begin
      logic [2:0] c;
      c = 3'(i % N);
      drive(1'b1, c == 3'd0, MSG_NONE, 1'b0);
      n_vec++;
      if ({out_nd_a, out_chan_a, out_first_a, error_a, out_data_a, out_m_a} !==
          {1'b1, c, c == 3'd0, 1'b0, in_data, in_m}) begin
        n_bad++;
        $display("FAIL default_frames[%0d]: got nd=%b chan=%0d first=%b err=%b data=%h m=%b, want 1 %0d %b 0 %h %b",
                 i, out_nd_a, out_chan_a, out_first_a, error_a, out_data_a, out_m_a, c, c == 3'd0, in_data, in_m);
      end
    end
  endtask

  // Frame 0 writes A5 and commits mid-frame; frame 1 writes 00 (plus an out-of-range chunk) and commits.
  task automatic test_mask_commit();
    logic [7:0] exp_mask [3];
    exp_mask[0] = 8'hFF;
    exp_mask[1] = 8'hA5;
    exp_mask[2] = 8'h00;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < N; c++) begin
        logic [31:0] msg;
        logic        mv;
        logic        e_nd, e_first;
        logic [2:0]  c3;
        c3  = 3'(c);
        msg = MSG_NONE;
        mv  = 1'b0;
        if (f == 0 && c == 2) begin msg = wr_msg(0, 16'h00A5); mv = 1'b1; end
        if (f == 0 && c == 4) begin msg = MSG_COMMIT;          mv = 1'b1; end
        if (f == 1 && c == 1) begin msg = wr_msg(0, 16'h0000); mv = 1'b1; end
        if (f == 1 && c == 3) begin msg = MSG_COMMIT;          mv = 1'b1; end
        if (f == 1 && c == 5) begin msg = wr_msg(1, 16'hFFFF); mv = 1'b1; end
        drive(1'b1, c == 0, msg, mv);
        e_nd    = exp_mask[f][c];
        e_first = e_nd && !seen;
        seen    = seen | e_nd;
        n_vec++;
        if ({out_nd_a, out_first_a} !== {e_nd, e_first} ||
            (e_nd && ({out_chan_a, out_data_a} !== {c3, in_data}))) begin
          n_bad++;
          $display("FAIL mask_commit f%0d c%0d: got nd=%b first=%b chan=%0d data=%h, want nd=%b first=%b chan=%0d data=%h",
                   f, c, out_nd_a, out_first_a, out_chan_a, out_data_a, e_nd, e_first, c3, in_data);
        end
      end
    end
  endtask

  task automatic test_resync();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, c == 0, MSG_NONE, 1'b0);
      n_vec++;
      if ({out_nd_a, out_chan_a, error_a, out_nd_b, out_chan_b, error_b} !==
          {1'b1, 3'(c), 1'b0, 1'b1, 3'(c), 1'b0}) begin
        n_bad++;
        $display("FAIL resync_pre c%0d: got a(nd=%b chan=%0d err=%b) b(nd=%b chan=%0d err=%b), want chan=%0d err=0",
                 c, out_nd_a, out_chan_a, error_a, out_nd_b, out_chan_b, error_b, c);
      end
    end
    drive(1'b1, 1'b1, MSG_NONE, 1'b0);
    n_vec++;
    if ({out_nd_a, out_chan_a, out_first_a, error_a} !== {1'b1, 3'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL resync_a_hit: got nd=%b chan=%0d first=%b err=%b, want 1 0 1 1",
               out_nd_a, out_chan_a, out_first_a, error_a);
    end
    n_vec++;
    if ({out_nd_b, out_chan_b, out_first_b, error_b} !== {1'b1, 3'd3, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL resync_b_hit: got nd=%b chan=%0d first=%b err=%b, want 1 3 0 1",
               out_nd_b, out_chan_b, out_first_b, error_b);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, MSG_NONE, 1'b0);
      n_vec++;
      if ({out_chan_a, error_a, out_chan_b, error_b} !== {3'(k), 1'b1, 3'(k + 3), 1'b1}) begin
        n_bad++;
        $display("FAIL resync_post k%0d: got a_chan=%0d a_err=%b b_chan=%0d b_err=%b, want %0d 1 %0d 1",
                 k, out_chan_a, error_a, out_chan_b, error_b, k, k + 3);
      end
    end
  endtask

  // Commit on a channel-0 sample waits a frame; a mid-frame reset drops an uncommitted write.
  task automatic test_commit_same_cycle();
    logic [7:0] exp_mask [6];
    exp_mask[0] = 8'hFF;
    exp_mask[1] = 8'hFF;
    exp_mask[2] = 8'h0F;
    exp_mask[3] = 8'h0F;
    exp_mask[4] = 8'hFF;
    exp_mask[5] = 8'hFF;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      logic seen;
      int   len;
      seen = 1'b0;
      len  = (f == 3) ? 3 : N;
      for (int c = 0; c < len; c++) begin
        logic [31:0] msg;
        logic        mv;
        logic        e_nd, e_first;
        logic [2:0]  c3;
        c3  = 3'(c);
        msg = MSG_NONE;
        mv  = 1'b0;
        if (f == 0 && c == 3) begin msg = wr_msg(0, 16'h000F); mv = 1'b1; end
        if (f == 1 && c == 0) begin msg = MSG_COMMIT;          mv = 1'b1; end
        if (f == 3 && c == 1) begin msg = wr_msg(0, 16'h0000); mv = 1'b1; end
        if (f == 4 && c == 2) begin msg = MSG_COMMIT;          mv = 1'b1; end
        drive(1'b1, c == 0, msg, mv);
        e_nd    = exp_mask[f][c];
        e_first = e_nd && !seen;
        seen    = seen | e_nd;
        n_vec++;
        if ({out_nd_a, out_first_a} !== {e_nd, e_first} ||
            (e_nd && ({out_chan_a, out_data_a} !== {c3, in_data}))) begin
          n_bad++;
          $display("FAIL same_cycle f%0d c%0d: got nd=%b first=%b chan=%0d data=%h, want nd=%b first=%b chan=%0d data=%h",
                   f, c, out_nd_a, out_first_a, out_chan_a, out_data_a, e_nd, e_first, c3, in_data);
        end
      end
      if (f == 3) begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, MSG_NONE, 1'b0);
        rst_n = 1'b1;
        n_vec++;
        if ({out_nd_a, out_data_a, out_m_a, out_chan_a, out_first_a, locked_a, error_a,
             out_nd_b, locked_b} !== 42'h0) begin
          n_bad++;
          $display("FAIL midframe_reset: got nd=%b data=%h chan=%0d first=%b locked=%b err=%b b_nd=%b b_locked=%b, want all 0",
                   out_nd_a, out_data_a, out_chan_a, out_first_a, locked_a, error_a, out_nd_b, locked_b);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_nd     = 1'b0;
    in_first  = 1'b0;
    in_data   = '0;
    in_m      = '0;
    in_msg    = '0;
    in_msg_nd = 1'b0;
    @(negedge clk);
    test_reset();
    test_search_drop();
    test_default_frames();
    test_mask_commit();
    test_resync();
    test_commit_same_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
